// File: rtl/pin_capt_pkg.sv
// Shared types and helpers for the pin_capt capture sequencer.
package pin_capt_pkg;

    localparam int FINE_BITS = 3;
    localparam int CNT_W_DEF = 16;
    localparam int WID_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        WAIT_FALL
    } capt_state_t;

    typedef struct packed {
        logic [CNT_W_DEF+FINE_BITS-1:0] start;
        logic [WID_W_DEF-1:0]           width;
    } pulse_rec_t;

    // Clamp a raw fine-unit difference to the largest value a wid_w-bit field holds.
    function automatic logic [31:0] sat_width(input logic [31:0] diff, input int unsigned wid_w);
        logic [31:0] lim;
        lim = (32'd1 << wid_w) - 32'd1;
        return (diff > lim) ? lim : diff;
    endfunction

endpackage

// File: rtl/pin_capt_ctrl_fifo.sv
// Synchronous show-ahead FIFO with count-based full/empty; a pop frees a slot for a same-cycle push.
module ev_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pin_capt_ctrl.sv
// Capture sequencer: turns pin_capt edge strobes into {start, width} pulse records behind a valid/ready FIFO.
module pin_capt_ctrl
    import pin_capt_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WID_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk300,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [7:0]             num_pulses,
    input  logic [WID_W-1:0]       min_width,
    input  logic                   str,
    input  logic                   pin_out,
    input  logic [2:0]             ptime,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [CNT_W+2:0]       ev_start,
    output logic [WID_W-1:0]       ev_width,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);
    localparam int TS_W  = CNT_W + FINE_BITS;
    localparam int REC_W = TS_W + WID_W;

    capt_state_t      state;
    capt_state_t      state_nx;
    logic [CNT_W-1:0] coarse;
    logic [TS_W-1:0]  rise_ts;
    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  diff;
    logic [WID_W-1:0] width_c;
    logic [7:0]       num_q;
    logic [7:0]       pcnt;
    logic [WID_W-1:0] minw_q;
    logic             push_q;
    logic             last_q;
    logic [REC_W-1:0] rec_q;
    logic [REC_W-1:0] rd_rec;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             drop;
    logic             start_run;
    logic             finish;
    logic             rise_take;
    logic             push_take;

    assign ts      = {coarse, ptime};
    assign diff    = ts - rise_ts;
    assign width_c = WID_W'(sat_width(32'(diff), WID_W));

    assign busy     = (state != IDLE);
    assign ev_valid = !fifo_empty;
    assign pop      = ev_valid && ev_ready;
    assign drop     = push_q && fifo_full && !pop;
    assign ev_start = rd_rec[REC_W-1:WID_W];
    assign ev_width = rd_rec[WID_W-1:0];

    always_comb begin
        state_nx  = state;
        start_run = 1'b0;
        rise_take = 1'b0;
        push_take = 1'b0;
        // The record of the final pulse is written one cycle after its falling
        // strobe; the run ends in that write cycle, so busy drops the cycle after.
        finish    = push_q && last_q;
        done      = finish && !abort;
        case (state)
            IDLE: begin
                if (arm) begin
                    start_run = !abort;
                    state_nx  = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (finish) begin
                    state_nx = IDLE;
                end else if (str && pin_out) begin
                    rise_take = 1'b1;
                    state_nx  = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                if (str && pin_out) begin
                    rise_take = 1'b1;
                end else if (str && !pin_out) begin
                    push_take = (width_c >= minw_q) && !abort;
                    state_nx  = WAIT_RISE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk300) begin
        if (rst) begin
            state    <= IDLE;
            coarse   <= '0;
            rise_ts  <= '0;
            num_q    <= '0;
            minw_q   <= '0;
            pcnt     <= '0;
            push_q   <= 1'b0;
            last_q   <= 1'b0;
            rec_q    <= '0;
            overflow <= 1'b0;
        end else begin
            state  <= state_nx;
            push_q <= 1'b0;
            last_q <= 1'b0;
            if (start_run) begin
                coarse   <= '0;
                num_q    <= num_pulses;
                minw_q   <= min_width;
                pcnt     <= '0;
                overflow <= 1'b0;
            end else if (busy) begin
                coarse <= coarse + 1'b1;
            end
            if (rise_take) begin
                rise_ts <= ts;
            end
            if (push_take) begin
                push_q <= 1'b1;
                rec_q  <= {rise_ts, width_c};
                pcnt   <= pcnt + 8'd1;
                last_q <= (num_q != 8'd0) && ((pcnt + 8'd1) == num_q);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    ev_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk300),
        .rst     (rst),
        .push    (push_q),
        .wr_data (rec_q),
        .pop     (pop),
        .rd_data (rd_rec),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_pin_capt_ctrl.sv
// Bench for pin_capt_ctrl: directed scenarios plus random strobes against a record-level reference model.
module tb_pin_capt_ctrl;
    import pin_capt_pkg::*;

    logic        clk300 = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_pulses = '0;
    logic [11:0] min_width = '0;
    logic        str = 1'b0;
    logic        pin_out = 1'b0;
    logic [2:0]  ptime = '0;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [18:0] ev_start;
    logic [11:0] ev_width;
    logic        busy;
    logic        done;
    logic        overflow;

    // small-counter instance used only for the timestamp wrap check
    logic        w_arm = 1'b0;
    logic        w_str = 1'b0;
    logic        w_pin = 1'b0;
    logic [2:0]  w_ptime = '0;
    logic        w_valid;
    logic [6:0]  w_start;
    logic [11:0] w_width;
    logic        w_busy;
    logic        w_done;
    logic        w_ovf;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk300 = ~clk300;

    pin_capt_ctrl #(.CNT_W(16), .WID_W(12), .FIFO_DEPTH(4)) dut (
        .clk300(clk300), .rst(rst), .arm(arm), .abort(abort),
        .num_pulses(num_pulses), .min_width(min_width),
        .str(str), .pin_out(pin_out), .ptime(ptime),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_start(ev_start), .ev_width(ev_width),
        .busy(busy), .done(done), .overflow(overflow)
    );

    pin_capt_ctrl #(.CNT_W(4), .WID_W(12), .FIFO_DEPTH(4)) dut_wrap (
        .clk300(clk300), .rst(rst), .arm(w_arm), .abort(1'b0),
        .num_pulses(8'd1), .min_width(12'd0),
        .str(w_str), .pin_out(w_pin), .ptime(w_ptime),
        .ev_valid(w_valid), .ev_ready(1'b0),
        .ev_start(w_start), .ev_width(w_width),
        .busy(w_busy), .done(w_done), .overflow(w_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: run-level state, a record queue standing for the FIFO,
    // and a one-cycle pending record matching the documented write latency.
    pulse_rec_t  mq[$];
    bit          m_busy = 0;
    bit          m_ovf = 0;
    bit          m_have = 0;
    int unsigned m_rise = 0;
    int unsigned m_coarse = 0;
    int unsigned m_num = 0;
    int unsigned m_minw = 0;
    int unsigned m_cnt = 0;
    bit          m_pend = 0;
    bit          m_pend_last = 0;
    pulse_rec_t  m_pend_rec;

    task automatic tick();
        bit          was_busy;
        bit          n_pend;
        bit          n_last;
        pulse_rec_t  n_rec;
        int unsigned t;
        int unsigned w;
        @(negedge clk300);
        check("ev_valid", 32'(ev_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("ev_start", 32'(ev_start), 32'(mq[0].start));
            check("ev_width", 32'(ev_width), 32'(mq[0].width));
        end
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_pend && m_pend_last && !abort));
        check("overflow", 32'(overflow), 32'(m_ovf));

        if (mq.size() > 0 && ev_ready) void'(mq.pop_front());
        if (m_pend) begin
            if (mq.size() < 4) mq.push_back(m_pend_rec);
            else m_ovf = 1;
        end
        was_busy = m_busy;
        n_pend = 0;
        n_last = 0;
        n_rec = '0;
        if (!m_busy) begin
            if (arm && !abort) begin
                m_busy = 1; m_num = num_pulses; m_minw = min_width;
                m_cnt = 0; m_ovf = 0; m_have = 0; m_coarse = 0;
            end
        end else if (abort) begin
            m_busy = 0; m_have = 0;
        end else if (m_pend && m_pend_last) begin
            m_busy = 0;
        end else if (str) begin
            t = (m_coarse * 8 + ptime) % (1 << 19);
            if (pin_out) begin
                m_have = 1; m_rise = t;
            end else if (m_have) begin
                m_have = 0;
                w = (t + (1 << 19) - m_rise) % (1 << 19);
                if (w > 4095) w = 4095;
                if (w >= m_minw) begin
                    m_cnt++;
                    n_pend = 1;
                    n_last = (m_num != 0) && (m_cnt == m_num);
                    n_rec.start = 19'(m_rise);
                    n_rec.width = 12'(w);
                end
            end
        end
        if (was_busy) m_coarse = (m_coarse + 1) % (1 << 16);
        m_pend = n_pend;
        m_pend_last = n_last;
        m_pend_rec = n_rec;

        @(posedge clk300);
        #1;
        arm = 0;
        abort = 0;
        str = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic lvl, input logic [2:0] ph);
        str = 1; pin_out = lvl; ptime = ph;
        tick();
    endtask

    task automatic start_run(input logic [7:0] n, input logic [11:0] mw);
        num_pulses = n; min_width = mw; arm = 1;
        tick();
    endtask

    task automatic drain();
        ev_ready = 1;
        idle(6);
        ev_ready = 0;
    endtask

    initial begin
        logic line;
        line = 0;
        repeat (3) @(posedge clk300);
        @(negedge clk300);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_start", 32'(ev_start), 32'd0);
        check("rst_width", 32'(ev_width), 32'd0);
        @(posedge clk300);
        #1;
        rst = 0;

        // timestamp wrap on the 4-bit counter instance: rise at coarse 14, fall at coarse 2
        w_arm = 1;
        @(posedge clk300); #1; w_arm = 0;
        repeat (14) begin @(posedge clk300); #1; end
        w_str = 1; w_pin = 1; w_ptime = 5;
        @(posedge clk300); #1; w_str = 0;
        repeat (3) begin @(posedge clk300); #1; end
        w_str = 1; w_pin = 0; w_ptime = 5;
        @(posedge clk300); #1; w_str = 0;
        repeat (2) begin @(posedge clk300); #1; end
        check("wrap_valid", 32'(w_valid), 32'd1);
        check("wrap_start", 32'(w_start), 32'd117);
        check("wrap_width", 32'(w_width), 32'd32);
        check("wrap_busy", 32'(w_busy), 32'd0);

        // basic record: rise coarse 10 ph 3, fall coarse 15 ph 1
        start_run(8'd1, 12'd4);
        idle(10);
        strobe(1, 3);
        idle(4);
        strobe(0, 1);
        idle(2);
        check("t1_start", 32'(ev_start), 32'd83);
        check("t1_width", 32'(ev_width), 32'd38);
        drain();

        // glitch of 5 units rejected, 40-unit pulse kept
        start_run(8'd1, 12'd16);
        idle(2);
        strobe(1, 6);
        strobe(0, 3);
        idle(2);
        strobe(1, 0);
        idle(4);
        strobe(0, 0);
        idle(3);
        check("t2_width", 32'(ev_width), 32'd40);
        drain();

        // six pulses into a depth-4 FIFO with the consumer stalled
        start_run(8'd6, 12'd0);
        for (int i = 0; i < 6; i++) begin
            strobe(1, 3'($urandom_range(0, 7)));
            idle(1);
            strobe(0, 3'($urandom_range(0, 7)));
            idle(1);
        end
        idle(3);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        drain();

        // 600-cycle pulse saturates the width field
        start_run(8'd1, 12'd0);
        strobe(1, 0);
        idle(600);
        strobe(0, 0);
        idle(3);
        check("t5_width", 32'(ev_width), 32'd4095);
        drain();

        // abort mid-pulse, arm+abort together, then a normal run
        start_run(8'd1, 12'd0);
        strobe(1, 2);
        idle(2);
        abort = 1;
        tick();
        idle(2);
        arm = 1; abort = 1; num_pulses = 8'd1;
        tick();
        idle(2);
        check("t6_idle", 32'(busy), 32'd0);
        start_run(8'd1, 12'd0);
        strobe(1, 1);
        idle(3);
        strobe(0, 4);
        idle(3);
        check("t6_width", 32'(ev_width), 32'd35);
        drain();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            arm = ($urandom_range(0, 29) == 0);
            abort = ($urandom_range(0, 149) == 0);
            num_pulses = 8'($urandom_range(0, 6));
            min_width = 12'($urandom_range(0, 40));
            ev_ready = ($urandom_range(0, 2) != 0);
            ptime = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                str = 1;
                if ($urandom_range(0, 7) != 0) line = !line;
                pin_out = line;
            end
            tick();
        end
        ev_ready = 0;
        idle(4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
